pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 16, PC width in bits.
REQ-002 SHALL have parameter IMM_W, default 9, branch offset width (two's complement).
REQ-003 SHALL have parameter INC, default 2, sequential PC increment in bytes.
REQ-004 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port en  input  1  fetch advance enable (0 = pipeline stall, PC held).
REQ-008 SHALL have port halt  input  1  HLT decoded; freezes PC.
REQ-009 SHALL have port br_valid  input  1  branch instruction present, qualified by en.
REQ-010 SHALL have port br_mode  input  1  0 = PC-relative B, 1 = register BR.
REQ-011 SHALL have port ccc  input  3  condition code.
REQ-012 SHALL have port imm  input  IMM_W  signed branch offset.
REQ-013 SHALL have port br_pc  input  PC_W  address of the branch instruction.
REQ-014 SHALL have port br_reg  input  PC_W  register target for BR.
REQ-015 SHALL have port flags  input  3  {Z, V, N}, Z in bit 2, N in bit 0.
REQ-016 SHALL have port flags_busy  input  1  an in-flight instruction will still write flags.
REQ-017 SHALL have port pc  output  PC_W  current fetch PC, registered.
REQ-018 SHALL have port redirect  output  1  one-cycle registered pulse: taken branch loaded into pc.
REQ-019 SHALL have port stall  output  1  combinational; upstream must hold fetch/decode.
REQ-020 SHALL have port halted  output  1  registered; 1 while in HALTED.

Function
REQ-021 Condition: 000 Z=0; 001 Z=1; 010 Z=0 and N=0; 011 N=1; 100 Z=1 or (Z=0 and N=0); 101 N=1 or Z=1; 110 V=1; 111 always.
REQ-022 Target: br_mode=0 -> br_pc + INC + sign-extended imm; br_mode=1 -> br_reg; all arithmetic modulo 2^PC_W, wrap silently.
REQ-023 FSM states RUN, WAIT_FLAGS, HALTED; priority in RUN: halt > branch > sequential.
REQ-024 RUN, halt=1 and en=1: -> HALTED, pc unchanged; branch inputs ignored.
REQ-025 RUN, en=1, br_valid=1, ccc!=111, flags_busy=1: -> WAIT_FLAGS, capture ccc/br_mode/target, pc unchanged, stall=1 same cycle.
REQ-026 RUN, en=1, br_valid=1, otherwise: taken -> pc<=target, redirect=1 next cycle; not taken -> pc<=pc+INC.
REQ-027 RUN, en=1, no branch/halt: pc<=pc+INC; en=0: pc held, no state change, halt/br_valid ignored.
REQ-028 WAIT_FLAGS: stall=1 while flags_busy=1; on flags_busy=0 evaluate captured branch against current flags, update pc per REQ-026 regardless of en, -> RUN; halt ignored in this state.
REQ-029 HALTED: pc held, stall=0, redirect=0; exit only by rst.
REQ-030 Single-cycle branch resolution latency when flags_busy=0; redirect never asserted two consecutive cycles.

Reset
REQ-031 rst=1 at a rising edge: pc=RESET_PC, state=RUN, redirect=0, halted=0; captured branch discarded; overrides every other input, including mid-WAIT_FLAGS.

Structure
REQ-032 Shared package pc_pkg holds ccc enum (8 codes), flag bit-index constants, FSM state enum.
REQ-033 Sub-module branch_cond_eval (combinational ccc+flags -> take) instantiated once in pc_sequencer.

Verification
REQ-034 Reset, en=1 four cycles, no branch -> pc 0000,0002,0004,0006,0008; redirect=0.
REQ-035 br_pc=0010, imm=9'h1FC, ccc=001, flags=100, flags_busy=0 -> next pc=000E, redirect=1 one cycle; flags=000 -> pc=pc+2.
REQ-036 All 8 ccc x 8 flag combinations, br_pc=0, imm=4 -> pc=0006 taken / pc+2 per REQ-021.
REQ-037 ccc=000 with flags_busy=1 for 3 cycles, then flags=000 -> stall=1 for 3 cycles, pc held, then pc=target, redirect=1.
REQ-038 br_mode=1, br_reg=ABCD, ccc=111 -> pc=ABCD; br_pc=FFFE, imm=0, ccc=111 -> pc=0000 (wrap).
REQ-039 halt=1 -> halted=1, pc frozen 10 cycles despite br_valid; rst mid-WAIT_FLAGS -> pc=RESET_PC, state RUN, no redirect.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the PC sequencer: condition codes, flag bit
// positions and the sequencer FSM states.
package pc_pkg;

    typedef enum logic [2:0] {
        CCC_NE     = 3'b000,
        CCC_EQ     = 3'b001,
        CCC_GT     = 3'b010,
        CCC_LT     = 3'b011,
        CCC_GE     = 3'b100,
        CCC_LE     = 3'b101,
        CCC_OVF    = 3'b110,
        CCC_UNCOND = 3'b111
    } ccc_e;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_WAIT_FLAGS = 2'd1,
        ST_HALTED     = 2'd2
    } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch/branch bundle between the decode stage (master) and the PC sequencer (slave).
interface pc_sequencer_if #(
    parameter int PC_W  = 16,
    parameter int IMM_W = 9
);
    logic              en;
    logic              halt;
    logic              br_valid;
    logic              br_mode;
    logic [2:0]        ccc;
    logic [IMM_W-1:0]  imm;
    logic [PC_W-1:0]   br_pc;
    logic [PC_W-1:0]   br_reg;
    logic [2:0]        flags;
    logic              flags_busy;
    logic [PC_W-1:0]   pc;
    logic              redirect;
    logic              stall;
    logic              halted;

    modport master (
        output en, halt, br_valid, br_mode, ccc, imm, br_pc, br_reg, flags, flags_busy,
        input  pc, redirect, stall, halted
    );

    modport slave (
        input  en, halt, br_valid, br_mode, ccc, imm, br_pc, br_reg, flags, flags_busy,
        output pc, redirect, stall, halted
    );
endinterface

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluation: condition code plus {Z,V,N}
// flags to a take decision.
module branch_cond_eval
    import pc_pkg::*;
(
    input  logic [2:0] ccc_i,
    input  logic [2:0] flags_i,
    output logic       take_o
);
    logic z_flag;
    logic v_flag;
    logic n_flag;

    assign z_flag = flags_i[FLAG_Z];
    assign v_flag = flags_i[FLAG_V];
    assign n_flag = flags_i[FLAG_N];

    always_comb begin
        take_o = 1'b0;
        case (ccc_e'(ccc_i))
            CCC_NE:     take_o = ~z_flag;
            CCC_EQ:     take_o = z_flag;
            CCC_GT:     take_o = ~z_flag & ~n_flag;
            CCC_LT:     take_o = n_flag;
            CCC_GE:     take_o = z_flag | (~z_flag & ~n_flag);
            CCC_LE:     take_o = n_flag | z_flag;
            CCC_OVF:    take_o = v_flag;
            CCC_UNCOND: take_o = 1'b1;
            default:    take_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: sequential advance, conditional PC-relative/register
// branches with a wait state for in-flight flag writers, and a halt state.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter int              IMM_W    = 9,
    parameter int              INC      = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.slave  bus
);
    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              redirect_q, redirect_d;
    logic              halted_q, halted_d;
    logic [2:0]        cap_ccc_q, cap_ccc_d;
    logic [PC_W-1:0]   cap_target_q, cap_target_d;

    logic [PC_W-1:0]   imm_ext;
    logic [PC_W-1:0]   target;
    logic [PC_W-1:0]   pc_seq;
    logic [2:0]        eval_ccc;
    logic              take;
    logic              stall;

    assign imm_ext = PC_W'($signed(bus.imm));
    assign target  = bus.br_mode ? bus.br_reg : (bus.br_pc + PC_W'(INC) + imm_ext);
    assign pc_seq  = pc_q + PC_W'(INC);

    // A parked branch is judged on its captured code against the live flags.
    assign eval_ccc = (state_q == ST_WAIT_FLAGS) ? cap_ccc_q : bus.ccc;

    branch_cond_eval u_cond (
        .ccc_i   (eval_ccc),
        .flags_i (bus.flags),
        .take_o  (take)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redirect_d   = 1'b0;
        cap_ccc_d    = cap_ccc_q;
        cap_target_d = cap_target_q;
        stall        = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.en) begin
                    if (bus.halt) begin
                        state_d = ST_HALTED;
                    // The slot right after a redirect holds a wrong-path
                    // instruction, so its branch is squashed.
                    end else if (bus.br_valid && !redirect_q) begin
                        if ((ccc_e'(bus.ccc) != CCC_UNCOND) && bus.flags_busy) begin
                            state_d      = ST_WAIT_FLAGS;
                            cap_ccc_d    = bus.ccc;
                            cap_target_d = target;
                            stall        = 1'b1;
                        end else if (take) begin
                            pc_d       = target;
                            redirect_d = 1'b1;
                        end else begin
                            pc_d = pc_seq;
                        end
                    end else begin
                        pc_d = pc_seq;
                    end
                end
            end
            ST_WAIT_FLAGS: begin
                if (bus.flags_busy) begin
                    stall = 1'b1;
                end else begin
                    state_d = ST_RUN;
                    if (take) begin
                        pc_d       = cap_target_q;
                        redirect_d = 1'b1;
                    end else begin
                        pc_d = pc_seq;
                    end
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        halted_d = (state_d == ST_HALTED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            redirect_q   <= 1'b0;
            halted_q     <= 1'b0;
            cap_ccc_q    <= '0;
            cap_target_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            redirect_q   <= redirect_d;
            halted_q     <= halted_d;
            cap_ccc_q    <= cap_ccc_d;
            cap_target_q <= cap_target_d;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.redirect = redirect_q;
    assign bus.halted   = halted_q;
    assign bus.stall    = stall;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with an expected-result
// scoreboard queue.
module tb_pc_sequencer;
    logic clk;
    logic rst;

    pc_sequencer_if #(.PC_W(16), .IMM_W(9)) bus ();

    pc_sequencer #(
        .PC_W     (16),
        .IMM_W    (9),
        .INC      (2),
        .RESET_PC (16'h0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [15:0] pc;
        logic        redirect;
        logic        halted;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic cond_ref(input logic [2:0] c, input logic [2:0] f);
        logic z, v, n;
        z = f[2];
        v = f[1];
        n = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag,
                        input logic e, input logic h, input logic bv, input logic bm,
                        input logic [2:0] c, input logic [8:0] im,
                        input logic [15:0] bp, input logic [15:0] br,
                        input logic [2:0] f, input logic fb,
                        input logic exp_stall, input logic [15:0] epc,
                        input logic erd, input logic eh, input logic chk_stall = 1'b1);
        exp_t got;
        exp_t want;
        bus.en = e; bus.halt = h; bus.br_valid = bv; bus.br_mode = bm;
        bus.ccc = c; bus.imm = im; bus.br_pc = bp; bus.br_reg = br;
        bus.flags = f; bus.flags_busy = fb;
        #1;
        if (chk_stall) check({tag, ".stall"}, 32'(bus.stall), 32'(exp_stall));
        sb.push_back('{pc: epc, redirect: erd, halted: eh});
        @(posedge clk);
        #1;
        want = sb.pop_front();
        got  = '{pc: bus.pc, redirect: bus.redirect, halted: bus.halted};
        check({tag, ".pc"},       32'(got.pc),       32'(want.pc));
        check({tag, ".redirect"}, 32'(got.redirect), 32'(want.redirect));
        check({tag, ".halted"},   32'(got.halted),   32'(want.halted));
        $display("step %-12s en=%b halt=%b brv=%b ccc=%0d flags=%b busy=%b -> pc=%h redirect=%b halted=%b",
                 tag, e, h, bv, c, f, fb, bus.pc, bus.redirect, bus.halted);
    endtask

    initial begin
        logic [15:0] p;
        logic [15:0] epc;
        logic        t;

        bus.en = 0; bus.halt = 0; bus.br_valid = 0; bus.br_mode = 0;
        bus.ccc = 0; bus.imm = 0; bus.br_pc = 0; bus.br_reg = 0;
        bus.flags = 0; bus.flags_busy = 0;
        rst = 1'b1;
        @(negedge clk);
        step("reset", 0,0,0,0, 3'd0, 9'd0, 16'h0, 16'h0, 3'b000, 0, 0, 16'h0000, 0, 0, 1'b0);
        rst = 1'b0;

        for (int i = 1; i <= 4; i++)
            step("seq", 1,0,0,0, 3'd0, 9'd0, 16'h0, 16'h0, 3'b000, 0, 0, 16'(2*i), 0, 0);

        step("b_eq_taken", 1,0,1,0, 3'b001, 9'h1FC, 16'h0010, 16'h0, 3'b100, 0, 0, 16'h000E, 1, 0);
        step("idle",       0,0,0,0, 3'd0, 9'd0, 16'h0, 16'h0, 3'b000, 0, 0, 16'h000E, 0, 0);
        step("b_eq_nt",    1,0,1,0, 3'b001, 9'h1FC, 16'h0010, 16'h0, 3'b000, 0, 0, 16'h0010, 0, 0);

        p = 16'h0010;
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                t   = cond_ref(3'(c), 3'(f));
                epc = t ? 16'h0006 : p + 16'd2;
                step("ccc_flags", 1,0,1,0, 3'(c), 9'd4, 16'h0, 16'h0, 3'(f), 0, 0, epc, t, 0);
                step("idle",      0,0,0,0, 3'd0, 9'd0, 16'h0, 16'h0, 3'b000, 0, 0, epc, 0, 0);
                p = epc;
            end
        end

        step("wf_enter",   1,0,1,0, 3'b000, 9'd4, 16'h0000, 16'h0, 3'b100, 1, 1, p, 0, 0);
        step("wf_hold",    0,1,1,1, 3'b111, 9'd0, 16'h0100, 16'h5555, 3'b100, 1, 1, p, 0, 0);
        step("wf_hold2",   1,0,0,0, 3'b000, 9'd0, 16'h0200, 16'h0, 3'b100, 1, 1, p, 0, 0);
        step("wf_resolve", 0,0,0,0, 3'b001, 9'd0, 16'h0300, 16'h0, 3'b000, 0, 0, 16'h0006, 1, 0);
        step("after_wf",   1,0,0,0, 3'd0, 9'd0, 16'h0, 16'h0, 3'b000, 0, 0, 16'h0008, 0, 0);

        step("br_reg",     1,0,1,1, 3'b111, 9'd0, 16'h0, 16'hABCD, 3'b000, 1, 0, 16'hABCD, 1, 0);
        step("idle",       0,0,0,0, 3'd0, 9'd0, 16'h0, 16'h0, 3'b000, 0, 0, 16'hABCD, 0, 0);
        step("wrap",       1,0,1,0, 3'b111, 9'd0, 16'hFFFE, 16'h0, 3'b000, 0, 0, 16'h0000, 1, 0);
        step("no_b2b",     1,0,1,1, 3'b111, 9'd0, 16'h0, 16'h1234, 3'b000, 0, 0, 16'h0002, 0, 0);
        step("en0_ignore", 0,1,1,1, 3'b111, 9'd0, 16'h0, 16'h1234, 3'b000, 0, 0, 16'h0002, 0, 0);

        step("wf_enter2",  1,0,1,0, 3'b011, 9'd4, 16'h0, 16'h0, 3'b000, 1, 1, 16'h0002, 0, 0);
        rst = 1'b1;
        step("rst_wait",   0,0,0,0, 3'd0, 9'd0, 16'h0, 16'h0, 3'b001, 1, 1, 16'h0000, 0, 0);
        rst = 1'b0;
        step("post_rst",   1,0,0,0, 3'd0, 9'd0, 16'h0, 16'h0, 3'b001, 0, 0, 16'h0002, 0, 0);

        step("halt",       1,1,1,0, 3'b111, 9'd0, 16'h0040, 16'h0, 3'b000, 0, 0, 16'h0002, 0, 1);
        for (int i = 0; i < 10; i++)
            step("halted", 1, 1'(i), 1, 1'(i >> 1), 3'b000, 9'd4, 16'h0, 16'hBEEF, 3'b000, 1, 0, 16'h0002, 0, 1);
        rst = 1'b1;
        step("rst_halt",   0,0,0,0, 3'd0, 9'd0, 16'h0, 16'h0, 3'b000, 0, 0, 16'h0000, 0, 0);
        rst = 1'b0;
        step("post_halt",  1,0,0,0, 3'd0, 9'd0, 16'h0, 16'h0, 3'b000, 0, 0, 16'h0002, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
